// File: rtl/clip_obj_mem_arbiter_pkg.sv
// Shared constants and types for the clipper object RAM arbiter.
// Object/point geometry, host op codes and the arbiter FSM states.
package clip_obj_mem_arbiter_pkg;

    localparam int NUM_OBJ = 32;
    localparam int PTS     = 4;
    localparam int OBJ_W   = 5;
    localparam int PT_W    = 2;
    localparam int ADDR_W  = OBJ_W + PT_W;

    localparam logic [OBJ_W-1:0] LAST_OBJ = OBJ_W'(NUM_OBJ - 1);
    localparam logic [PT_W-1:0]  LAST_PT  = PT_W'(PTS - 1);

    typedef enum logic [1:0] {
        OP_WRPT = 2'b00,
        OP_DEL  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSVD = 2'b11
    } host_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/clip_obj_mem_arbiter_frame_timer.sv
// Free-running frame timer: counts 0..FRAME_CYCLES-1 and pulses
// frame_start for one cycle on the terminal count.
module clip_frame_timer #(
    parameter int FRAME_CYCLES = 1666668
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_start
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign frame_start = (cnt_q == CNT_LAST);

endmodule

// File: rtl/clip_obj_mem_arbiter.sv
// Shares the single-port clipper object RAM between host point writes and
// the per-frame refresh scan; owns the object-valid bitmap and dirty flag.
module clip_obj_mem_arbiter
    import clip_obj_mem_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FRAME_CYCLES = 1666668
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               host_req,
    input  logic [1:0]         host_op,
    input  logic [OBJ_W-1:0]   host_obj,
    input  logic [PT_W-1:0]    host_pt,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic               host_ack,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               scan_vld,
    output logic [DATA_W-1:0]  scan_data,
    output logic [OBJ_W-1:0]   scan_obj,
    output logic [PT_W-1:0]    scan_pt,
    output logic               scan_last,
    output logic               refresh_busy,
    output logic [NUM_OBJ-1:0] obj_map,
    output arb_state_e         dbg_state
);

    logic frame_start;

    clip_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start)
    );

    // Handshake: host_req is held until host_ack. A request is granted and
    // executed in one cycle; host_ack pulses the following cycle, and no new
    // grant is possible while that ack is on the wire.
    arb_state_e         state_q, state_d;
    logic [OBJ_W-1:0]   obj_q, obj_d;
    logic [PT_W-1:0]    pt_q, pt_d;
    logic               dirty_q, dirty_d;
    logic               slot_used_q, slot_used_d;
    logic [NUM_OBJ-1:0] map_q, map_d;
    logic               grant;
    logic               rd_en;
    logic               rd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            obj_q       <= '0;
            pt_q        <= '0;
            dirty_q     <= 1'b1;
            slot_used_q <= 1'b0;
            map_q       <= '0;
            host_ack    <= 1'b0;
            scan_vld    <= 1'b0;
            scan_obj    <= '0;
            scan_pt     <= '0;
            scan_last   <= 1'b0;
        end else begin
            state_q     <= state_d;
            obj_q       <= obj_d;
            pt_q        <= pt_d;
            dirty_q     <= dirty_d;
            slot_used_q <= slot_used_d;
            map_q       <= map_d;
            host_ack    <= grant;
            scan_vld    <= rd_en;
            scan_obj    <= rd_en ? obj_q : '0;
            scan_pt     <= rd_en ? pt_q : '0;
            scan_last   <= rd_last;
        end
    end

    always_comb begin
        state_d     = state_q;
        obj_d       = obj_q;
        pt_d        = pt_q;
        dirty_d     = dirty_q;
        slot_used_d = slot_used_q;
        map_d       = map_q;
        grant       = 1'b0;
        rd_en       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start && dirty_q) begin
                    state_d     = ST_SCAN;
                    obj_d       = '0;
                    pt_d        = '0;
                    slot_used_d = 1'b0;
                    dirty_d     = 1'b0;
                end
                grant = host_req && !host_ack;
            end
            ST_SCAN: begin
                if (host_req && (pt_q == '0) && !host_ack && !slot_used_q) begin
                    grant       = 1'b1;
                    slot_used_d = 1'b1;
                end else if (!map_q[obj_q]) begin
                    obj_d       = obj_q + 1'b1;
                    slot_used_d = 1'b0;
                    if (obj_q == LAST_OBJ) state_d = ST_IDLE;
                end else begin
                    rd_en    = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = {obj_q, pt_q};
                    pt_d     = pt_q + 1'b1;
                    if (pt_q == LAST_PT) begin
                        obj_d       = obj_q + 1'b1;
                        slot_used_d = 1'b0;
                        if (obj_q == LAST_OBJ) state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A host op in the same cycle as the scan launch wins over the dirty
        // clear, so the change is guaranteed to be picked up by some scan.
        if (grant) begin
            case (host_op_e'(host_op))
                OP_WRPT: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {host_obj, host_pt};
                    mem_wdata = host_wdata;
                    dirty_d   = 1'b1;
                    if (host_pt == LAST_PT) map_d[host_obj] = 1'b1;
                end
                OP_DEL: begin
                    map_d[host_obj] = 1'b0;
                    dirty_d         = 1'b1;
                end
                OP_CLR: begin
                    map_d   = '0;
                    dirty_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Final word: last point of an object with no valid object above it.
    assign rd_last = rd_en && (pt_q == LAST_PT) && (((map_q >> obj_q) >> 1) == '0);

    assign scan_data    = scan_vld ? mem_rdata : '0;
    assign refresh_busy = (state_q == ST_SCAN);
    assign obj_map      = map_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_clip_obj_mem_arbiter.sv
// Randomised and directed checks of clip_obj_mem_arbiter against a
// cursor-based reference model of the refresh scan and host arbitration.
module tb_clip_obj_mem_arbiter;
    import clip_obj_mem_arbiter_pkg::*;

    localparam int FC = 300;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          host_req = 1'b0;
    logic [1:0]    host_op = '0;
    logic [4:0]    host_obj = '0;
    logic [1:0]    host_pt = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack, mem_en, mem_we;
    logic [6:0]    mem_addr;
    logic [DW-1:0] mem_wdata, scan_data;
    logic [DW-1:0] mem_rdata = '0;
    logic          scan_vld, scan_last, refresh_busy;
    logic [4:0]    scan_obj;
    logic [1:0]    scan_pt;
    logic [31:0]   obj_map;
    arb_state_e    dbg_state;

    clip_obj_mem_arbiter #(.DATA_W(DW), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_op(host_op), .host_obj(host_obj),
        .host_pt(host_pt), .host_wdata(host_wdata), .host_ack(host_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .scan_vld(scan_vld), .scan_data(scan_data), .scan_obj(scan_obj),
        .scan_pt(scan_pt), .scan_last(scan_last),
        .refresh_busy(refresh_busy), .obj_map(obj_map), .dbg_state(dbg_state)
    );

    // single-port RAM with one-cycle read latency
    logic [DW-1:0] ram [128] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_bad = 0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: scan position is a flat cursor 0..127 = obj*4+pt
    bit          m_scan, m_slot, m_dirty, m_ack, m_prev_rd;
    int          m_cur, m_tcnt;
    logic [31:0] m_map;
    logic [31:0] m_mem [128];

    // host driver state
    logic [40:0] op_q[$];
    bit          h_pend;

    // observation counters
    int busy_cnt, vld_cnt, we_cnt;
    logic [31:0] last_data;

    task automatic model_reset();
        m_scan = 0; m_slot = 0; m_dirty = 1; m_ack = 0; m_prev_rd = 0;
        m_cur = 0; m_tcnt = 0; m_map = '0;
        exp_q.delete();
    endtask

    task automatic push_op(input logic [1:0] op, input int obj, input int pt, input logic [31:0] d);
        op_q.push_back({op, 5'(obj), 2'(pt), d});
    endtask

    // one clock cycle: drive at negedge, compare, advance model, next negedge
    task automatic step();
        bit g, rd, fs, was_scan, is_wr, last;
        int o, p;
        logic [40:0] cur_op;
        logic [39:0] e;
        if (h_pend && m_ack) h_pend = 0;
        if (!h_pend && op_q.size() > 0) begin
            cur_op = op_q.pop_front();
            {host_op, host_obj, host_pt, host_wdata} = cur_op;
            h_pend = 1;
        end
        host_req = h_pend;
        #1;
        g = 0; rd = 0;
        o = m_cur / 4; p = m_cur % 4;
        fs = (m_tcnt == FC - 1);
        was_scan = m_scan;
        if (!m_scan) g = host_req && !m_ack;
        else if (host_req && p == 0 && !m_ack && !m_slot) g = 1;
        else if (m_map[o]) rd = 1;
        is_wr = g && (host_op == OP_WRPT);

        check("host_ack", host_ack, m_ack);
        check("busy", refresh_busy, m_scan);
        check("obj_map", obj_map, m_map);
        check("mem_en", mem_en, rd || is_wr);
        check("mem_we", mem_we, is_wr);
        if (rd) check("rd_addr", mem_addr, {5'(o), 2'(p)});
        if (is_wr) check("wr_word", {mem_addr, mem_wdata}, {host_obj, host_pt, host_wdata});
        check("scan_vld", scan_vld, m_prev_rd);
        if (m_prev_rd && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan_word", {scan_obj, scan_pt, scan_last, scan_data}, e);
        end else begin
            check("scan_last", scan_last, 1'b0);
        end
        if (refresh_busy) busy_cnt++;
        if (scan_vld) vld_cnt++;
        if (mem_we) we_cnt++;
        if (scan_vld && scan_last) last_data = scan_data;

        if (rd) begin
            last = (p == 3) && ((o == 31) || ((m_map >> (o + 1)) == 0));
            exp_q.push_back({5'(o), 2'(p), last, m_mem[m_cur]});
        end
        m_prev_rd = rd;
        if (was_scan) begin
            if (g) m_slot = 1;
            else begin
                if (!m_map[o]) m_cur = (o + 1) * 4;
                else m_cur = m_cur + 1;
                if (m_cur % 4 == 0) m_slot = 0;
                if (m_cur >= 128) m_scan = 0;
            end
        end else if (fs && m_dirty) begin
            m_scan = 1; m_cur = 0; m_slot = 0; m_dirty = 0;
        end
        if (g) begin
            case (host_op)
                OP_WRPT: begin
                    m_mem[host_obj * 4 + host_pt] = host_wdata;
                    m_dirty = 1;
                    if (host_pt == 3) m_map[host_obj] = 1'b1;
                end
                OP_DEL: begin m_map[host_obj] = 1'b0; m_dirty = 1; end
                OP_CLR: begin m_map = '0; m_dirty = 1; end
                default: ;
            endcase
        end
        m_ack = g;
        m_tcnt = (m_tcnt + 1) % FC;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        busy_cnt = 0; vld_cnt = 0; we_cnt = 0;
    endtask

    // called at a negedge; checks outputs while reset is asserted
    task automatic do_reset(input int cycles);
        host_req = 0; h_pend = 0; op_q.delete();
        rst_n = 1'b0;
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_ack", host_ack, 1'b0);
        check("rst_scan_vld", scan_vld, 1'b0);
        check("rst_scan_last", scan_last, 1'b0);
        check("rst_busy", refresh_busy, 1'b0);
        check("rst_obj_map", obj_map, 32'h0);
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_cursor(input int target);
        int n;
        n = 0;
        while (!(m_scan && m_cur >= target) && n < 800) begin
            step();
            n++;
        end
        check("wait_cursor", (m_scan && m_cur >= target), 1'b1);
    endtask

    task automatic wait_idle_at(input int t);
        int n;
        n = 0;
        while (!(!m_scan && m_tcnt == t) && n < 800) begin
            step();
            n++;
        end
        check("wait_idle", (!m_scan && m_tcnt == t), 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        h_pend = 0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // no host traffic: empty scan of 32 cycles, then no scan next frame
        clear_counts();
        run(FC + 40);
        check("first_busy", busy_cnt, 32);
        check("first_vld", vld_cnt, 0);
        clear_counts();
        run(FC);
        check("clean_busy", busy_cnt, 0);

        // obj 3 fully written, then one frame
        for (int i = 0; i < 4; i++) push_op(OP_WRPT, 3, i, 32'hA0 + i);
        run(10);
        check("map_obj3", obj_map, 32'h8);
        clear_counts();
        run(FC);
        check("obj3_vld", vld_cnt, 4);
        check("obj3_last", last_data, 32'hA3);

        // write requested mid-object is deferred to the next object boundary
        push_op(OP_WRPT, 3, 0, 32'hA0);
        wait_cursor(13);
        push_op(OP_WRPT, 5, 3, 32'hC3);
        run(400);

        // delete obj 3 while the scan sits on obj 1
        push_op(OP_DEL, 5, 0, 32'h0);
        for (int i = 0; i < 4; i++) push_op(OP_WRPT, 1, i, 32'hB0 + i);
        wait_cursor(4);
        push_op(OP_DEL, 3, 0, 32'h0);
        run(2 * FC);
        check("map_after_del", obj_map, 32'h2);

        // back-to-back requests in IDLE: one grant every two cycles
        wait_idle_at(10);
        for (int i = 0; i < 6; i++) push_op(OP_WRPT, 8 + i, 1, $urandom);
        clear_counts();
        run(12);
        check("b2b_grants", we_cnt, 6);

        // reset in the middle of a scan, then the first frame rescans
        push_op(OP_WRPT, 2, 3, 32'hD3);
        wait_cursor(4);
        do_reset(2);
        clear_counts();
        run(FC + 40);
        check("post_rst_busy", busy_cnt, 32);

        // randomised traffic
        for (int i = 0; i < 20 * FC; i++) begin
            if (op_q.size() == 0 && !h_pend && $urandom_range(0, 5) == 0) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 70)      push_op(OP_WRPT, $urandom_range(0, 31), $urandom_range(0, 3), $urandom);
                else if (r < 85) push_op(OP_DEL, $urandom_range(0, 31), 0, 32'h0);
                else if (r < 90) push_op(OP_CLR, 0, 0, 32'h0);
                else             push_op(OP_RSVD, $urandom_range(0, 31), $urandom_range(0, 3), $urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
